// File: rtl/pulse_width_meter.sv
// Pulse width meter: armed by start, measures start->rising-edge delay and high time of
// a synchronised pulse_in, then checks both against expected values.
module pulse_width_meter #(
    parameter int CNT_W          = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int EXP_DELAY      = 4,
    parameter int EXP_WIDTH      = 8,
    parameter int WIDTH_TOL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pulse_in,
    output logic             ready,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] delay_count,
    output logic [CNT_W-1:0] width_count,
    output logic             meas_pass,
    output logic             timeout_err,
    output logic             ovf_err
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] SYNC_OFS = CNT_W'(SYNC_STAGES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam int               W_LO     = (EXP_WIDTH > WIDTH_TOL) ? EXP_WIDTH - WIDTH_TOL : 0;
    localparam int               W_HI     = EXP_WIDTH + WIDTH_TOL;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pulse_s, pulse_d, rise, fall;
    logic [CNT_W-1:0]       d_cnt, d_cnt_n, w_cnt, w_cnt_n, delay_q, delay_n;
    logic [TMR_W-1:0]       tmr, tmr_n;
    logic                   ovf_q, ovf_n, to_n, pass_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            pulse_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts one stage per clock.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            pulse_d <= pulse_s;
        end
    end

    assign pulse_s = sync_q[SYNC_STAGES-1];
    assign rise    = pulse_s & ~pulse_d;
    assign fall    = ~pulse_s & pulse_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_n = state;
        d_cnt_n = d_cnt;
        w_cnt_n = w_cnt;
        delay_n = delay_q;
        ovf_n   = ovf_q;
        tmr_n   = tmr + TMR_W'(1);
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                tmr_n = '0;
                if (start) begin
                    state_n = WAIT_EDGE;
                    d_cnt_n = '0;
                    w_cnt_n = '0;
                    delay_n = '0;
                    ovf_n   = 1'b0;
                end
            end
            WAIT_EDGE: begin
                if (rise) begin
                    // The rise reaches the synchroniser output SYNC_STAGES cycles late; take those back off.
                    state_n = MEASURE;
                    delay_n = (d_cnt >= SYNC_OFS) ? d_cnt - SYNC_OFS : '0;
                    w_cnt_n = CNT_W'(1);
                    tmr_n   = '0;
                end else if (tmr == TMR_LAST) begin
                    state_n = DONE;
                    delay_n = d_cnt;
                    to_n    = 1'b1;
                end else if (d_cnt != CNT_MAX) begin
                    d_cnt_n = d_cnt + CNT_W'(1);
                    if (d_cnt_n == CNT_MAX) ovf_n = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_n = DONE;
                end else if (tmr == TMR_LAST) begin
                    state_n = DONE;
                    to_n    = 1'b1;
                end else if (pulse_s && w_cnt != CNT_MAX) begin
                    w_cnt_n = w_cnt + CNT_W'(1);
                    if (w_cnt_n == CNT_MAX) ovf_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                tmr_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        pass_n = !to_n && !ovf_n && (delay_n == CNT_W'(EXP_DELAY)) &&
                 (int'(w_cnt_n) >= W_LO) && (int'(w_cnt_n) <= W_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            d_cnt       <= '0;
            w_cnt       <= '0;
            delay_q     <= '0;
            tmr         <= '0;
            ovf_q       <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            meas_valid  <= 1'b0;
            delay_count <= '0;
            width_count <= '0;
            meas_pass   <= 1'b0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            state      <= state_n;
            d_cnt      <= d_cnt_n;
            w_cnt      <= w_cnt_n;
            delay_q    <= delay_n;
            tmr        <= tmr_n;
            ovf_q      <= ovf_n;
            ready      <= (state_n == IDLE);
            busy       <= (state_n == WAIT_EDGE) || (state_n == MEASURE);
            meas_valid <= (state_n == DONE);
            // Results are captured on the edge that enters DONE so they line up with meas_valid.
            if (state_n == DONE) begin
                delay_count <= delay_n;
                width_count <= w_cnt_n;
                meas_pass   <= pass_n;
                timeout_err <= to_n;
                ovf_err     <= ovf_n;
            end
        end
    end

endmodule
